spi_cap_ctrl: RTL and testbench

Controller that sits downstream of the SPI capture datapath. It accepts the 32-bit DO/DI word pairs produced on each capture-ready pulse and gates them through an arm/trigger qualifier. Qualified records are buffered in a small FIFO. A serializer FSM then streams each record as a framed 9-byte packet to the UART transmitter over a valid/ready byte handshake. Overflow is counted, not back-pressured, because the SPI side cannot be stalled.

---
 rtl/spi_cap_ctrl_pkg.sv | 41 ++++
 rtl/spi_cap_fifo.sv | 68 ++++++
 rtl/spi_cap_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_cap_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cap_ctrl_pkg.sv
// Shared types and constants for the SPI capture controller.
// Frame constants, FSM state encodings and the frame byte selector.
package spi_cap_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 9;

    typedef enum logic [1:0] {
        CAP_DISARMED,
        CAP_WAIT_TRIG,
        CAP_CAPTURING
    } cap_state_e;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

    // Byte idx of a frame: 0 is sync, then {do,di} MSB first.
    function automatic logic [7:0] frame_byte(
        input logic [63:0] rec,
        input logic [3:0]  idx,
        input logic [7:0]  sync
    );
        logic [7:0] b;
        b = sync;
        case (idx)
            4'd1:    b = rec[63:56];
            4'd2:    b = rec[55:48];
            4'd3:    b = rec[47:40];
            4'd4:    b = rec[39:32];
            4'd5:    b = rec[31:24];
            4'd6:    b = rec[23:16];
            4'd7:    b = rec[15:8];
            4'd8:    b = rec[7:0];
            default: b = sync;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_cap_fifo.sv
// Synchronous record FIFO, depth 2**AW, read data registered on pop.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, level.
module spi_cap_fifo #(
    parameter int AW = 3,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign rdata = rdata_q;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdata_d  = rdata_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_cap_ctrl.sv
// Arm/trigger qualifier, record FIFO and 9-byte UART frame serializer.
// In: cap_ready/cap_do/cap_di, arm, trig_*, tx_ready. Out: tx_*, status.
module spi_cap_ctrl
    import spi_cap_ctrl_pkg::*;
#(
    parameter int         FIFO_AW   = 3,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_ready,
    input  logic [31:0]      cap_do,
    input  logic [31:0]      cap_di,
    input  logic             arm,
    input  logic             trig_en,
    input  logic [31:0]      trig_mask,
    input  logic [31:0]      trig_value,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             triggered,
    output logic [FIFO_AW:0] fifo_level,
    output logic [15:0]      drop_cnt
);

    cap_state_e  cap_state_q, cap_state_d;
    ser_state_e  ser_state_q, ser_state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        match;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] rec;

    // rec stays stable through SEND since the FIFO is only read in IDLE.
    spi_cap_fifo #(
        .AW (FIFO_AW),
        .DW (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({cap_do, cap_di}),
        .pop   (pop),
        .rdata (rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign match = ((cap_do ^ trig_value) & trig_mask) == 32'd0;

    always_comb begin
        cap_state_d = cap_state_q;
        accept      = 1'b0;
        if (!arm) begin
            cap_state_d = CAP_DISARMED;
        end else begin
            unique case (cap_state_q)
                CAP_DISARMED: begin
                    cap_state_d = trig_en ? CAP_WAIT_TRIG : CAP_CAPTURING;
                end
                CAP_WAIT_TRIG: begin
                    if (cap_ready && match) begin
                        accept      = 1'b1;
                        cap_state_d = CAP_CAPTURING;
                    end
                end
                CAP_CAPTURING: begin
                    accept = cap_ready;
                end
                default: cap_state_d = CAP_DISARMED;
            endcase
        end
    end

    // Full is judged on the start-of-cycle state; a same-cycle pop
    // does not make room for this record.
    assign push = accept && !fifo_full;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && fifo_full && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        ser_state_d = ser_state_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        pop         = 1'b0;
        unique case (ser_state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    ser_state_d = SER_SEND;
                    cnt_d       = 4'd0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = SYNC_BYTE;
                end
            end
            SER_SEND: begin
                if (tx_ready) begin
                    if (cnt_q == 4'(FRAME_LEN - 1)) begin
                        ser_state_d = SER_IDLE;
                        tx_valid_d  = 1'b0;
                    end else begin
                        cnt_d     = cnt_q + 4'd1;
                        tx_data_d = frame_byte(rec, cnt_q + 4'd1, SYNC_BYTE);
                    end
                end
            end
            default: begin
                ser_state_d = SER_IDLE;
                tx_valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_state_q <= CAP_DISARMED;
            ser_state_q <= SER_IDLE;
            cnt_q       <= 4'd0;
            tx_data_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            cap_state_q <= cap_state_d;
            ser_state_q <= ser_state_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign drop_cnt  = drop_cnt_q;
    assign triggered = (cap_state_q == CAP_CAPTURING);

endmodule

// File: tb/tb_spi_cap_ctrl.sv
// Self-checking bench for spi_cap_ctrl: random records and stalls
// scored against a queue-based frame model.
module tb_spi_cap_ctrl;

    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_ready = 1'b0;
    logic [31:0] cap_do = '0;
    logic [31:0] cap_di = '0;
    logic        arm = 1'b0;
    logic        trig_en = 1'b0;
    logic [31:0] trig_mask = '0;
    logic [31:0] trig_value = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        triggered;
    logic [AW:0] fifo_level;
    logic [15:0] drop_cnt;

    spi_cap_ctrl #(
        .FIFO_AW   (AW),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_ready  (cap_ready),
        .cap_do     (cap_do),
        .cap_di     (cap_di),
        .arm        (arm),
        .trig_en    (trig_en),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .triggered  (triggered),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] exp_q[$];
    bit         m_arm   = 0;
    bit         m_cap   = 0;
    int         m_room  = -1;
    int         m_drops = 0;
    bit         rnd_rdy = 0;
    int         hs_cnt  = 0;

    task automatic push_rec(input logic [31:0] d, input logic [31:0] i);
        logic [63:0] r;
        r = {d, i};
        exp_q.push_back(8'hA5);
        for (int k = 7; k >= 0; k--) exp_q.push_back(r[k*8 +: 8]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_arm(input bit v);
        arm = v;
        tick();
        tick();
        m_arm = v;
        m_cap = v && !trig_en;
        @(negedge clk);
        chk("arm_triggered", triggered, m_cap);
    endtask

    task automatic cap(input logic [31:0] d, input logic [31:0] i);
        bit acc;
        cap_do    = d;
        cap_di    = i;
        cap_ready = 1'b1;
        acc = m_arm && (m_cap || ((d & trig_mask) == (trig_value & trig_mask)));
        if (acc) begin
            m_cap = 1;
            if (m_room == 0) begin
                m_drops++;
            end else begin
                if (m_room > 0) m_room--;
                push_rec(d, i);
            end
        end
        tick();
        cap_ready = 1'b0;
        chk("cap_triggered", triggered, m_cap);
        chk("cap_drop_cnt", drop_cnt, 64'(m_drops));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !tx_valid && fifo_level == 0)
               && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < budget, 1);
    endtask

    // Output monitor: scoreboard, stall hold and inter-frame gap.
    initial begin
        logic [7:0] prev_d;
        bit         prev_stall;
        bit         gap;
        int         pos;
        prev_d = '0;
        prev_stall = 0;
        gap = 0;
        pos = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                gap = 0;
                pos = 0;
            end else begin
                if (gap) chk("frame_gap", tx_valid, 0);
                gap = 0;
                if (prev_stall) begin
                    chk("hold_valid", tx_valid, 1);
                    chk("hold_data", tx_data, prev_d);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", exp_q.size(), 1);
                    end else begin
                        chk("frame_byte", tx_data, exp_q.pop_front());
                    end
                    hs_cnt++;
                    pos++;
                    if (pos == 9) begin
                        pos = 0;
                        gap = 1;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_d = tx_data;
            end
        end
    end

    initial begin
        int n;
        int base;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single record, latency and frame content
        set_arm(1);
        cap(32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        chk("lat_level_n1", fifo_level, 1);
        chk("lat_valid_n1", tx_valid, 0);
        @(negedge clk);
        chk("lat_valid_n2", tx_valid, 1);
        chk("lat_sync_n2", tx_data, 8'hA5);
        wait_drain(100);
        chk("idle_valid", tx_valid, 0);

        // Trigger qualification
        set_arm(0);
        trig_en    = 1'b1;
        trig_mask  = 32'hFF000000;
        trig_value = 32'h03000000;
        set_arm(1);
        cap(32'h05AA0000, $urandom);
        cap(32'h03BB0000, $urandom);
        cap(32'h07CC0000, $urandom);
        wait_drain(200);
        chk("trig_drop_cnt", drop_cnt, 0);

        // Overflow with the UART stalled: one record held by the
        // serializer, 2**AW in the FIFO, the rest dropped.
        set_arm(0);
        trig_en = 1'b0;
        set_arm(1);
        tx_ready = 1'b0;
        m_room = (1 << AW) + 1;
        for (int k = 0; k < (1 << AW) + 3; k++) cap($urandom, $urandom);
        m_room = -1;
        tick();
        tick();
        @(negedge clk);
        chk("ovf_level", fifo_level, 1 << AW);
        chk("ovf_drop_cnt", drop_cnt, 2);
        chk("ovf_valid", tx_valid, 1);
        chk("ovf_sync", tx_data, 8'hA5);
        tick();
        tx_ready = 1'b1;
        wait_drain(400);
        chk("ovf_level_end", fifo_level, 0);

        // Random back-pressure
        rnd_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 12)) tick();
            cap($urandom, $urandom);
        end
        wait_drain(600);
        rnd_rdy = 0;
        tx_ready = 1'b1;
        tick();

        // Disarm mid-frame with two records buffered
        for (int k = 0; k < 3; k++) cap($urandom, $urandom);
        tick();
        arm = 1'b0;
        m_arm = 0;
        m_cap = 0;
        tick();
        chk("disarm_triggered", triggered, 0);
        cap($urandom, $urandom);
        tick();
        cap($urandom, $urandom);
        wait_drain(200);
        chk("disarm_level", fifo_level, 0);

        // Reset during byte 4 of a frame
        set_arm(1);
        base = hs_cnt;
        for (int k = 0; k < 3; k++) cap($urandom, $urandom);
        n = 0;
        while (hs_cnt < base + 4 && n < 50) begin
            tick();
            n++;
        end
        chk("byte4_reached", n < 50, 1);
        rst = 1'b1;
        exp_q.delete();
        m_arm = 0;
        m_cap = 0;
        m_drops = 0;
        tick();
        chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_trig", triggered, 0);
        rst = 1'b0;
        set_arm(1);
        cap(32'hCAFEF00D, 32'h0BADBEEF);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_sync", tx_data, 8'hA5);
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
